knn_vote: RTL and testbench

- Downstream stage of the KNN core.
- Consumes the K nearest-neighbour indices produced when the core asserts its valid-out pulse.
- Looks up the class label of each index in a CPU-written label memory, tallies votes per class and emits the majority class.
- Tie-break favours the class of the nearest neighbour.
- Sits between the KNN core outputs and the CPU register file, so software reads a class instead of six indices.

---
 rtl/knn_vote_pkg.sv | 28 ++
 rtl/knn_label_ram.sv | 17 +
 rtl/knn_vote.sv | 110 +++++++++++
 tb/tb_knn_vote.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/knn_vote_pkg.sv
// knn_vote_pkg: shared parameters, FSM states and register bundle for the KNN vote stage
package knn_vote_pkg;
  localparam int K = 6;
  localparam int N_PTS = 128;
  localparam int IDX_W = 7;
  localparam int LABEL_W = 4;
  localparam int NUM_CLASSES = 10;
  localparam int CNT_W = 3;
  localparam int STEP_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_MAX, S_PICK, S_DONE} state_e;
  typedef struct packed {
    state_e state;
    logic [STEP_W-1:0] step;
    logic [K-1:0][IDX_W-1:0] idx;
    logic [K-1:0][LABEL_W-1:0] lab;
    logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0] mx;
    logic [1:0] nmax;
    logic [LABEL_W-1:0] win;
    logic found;
    logic busy;
    logic res_valid;
    logic [LABEL_W-1:0] res_label;
    logic [CNT_W-1:0] res_votes;
    logic res_tie;
    logic overrun;
  } vote_t;
endpackage

// File: rtl/knn_label_ram.sv
// knn_label_ram: N_PTS x LABEL_W label store, one write port, one synchronous read-first port
module knn_label_ram
  import knn_vote_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [LABEL_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [LABEL_W-1:0] rdata
);
  logic [LABEL_W-1:0] mem [N_PTS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest neighbour labels, nearest neighbour breaks ties
module knn_vote
  import knn_vote_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               lbl_we,
  input  logic [IDX_W-1:0]   lbl_waddr,
  input  logic [LABEL_W-1:0] lbl_wdata,
  input  logic               nb_valid,
  input  logic [K*IDX_W-1:0] nb_idx,
  output logic               busy,
  output logic               res_valid,
  output logic [LABEL_W-1:0] res_label,
  output logic [CNT_W-1:0]   res_votes,
  output logic               res_tie,
  output logic               overrun
);
  vote_t st_q, st_d;
  logic [IDX_W-1:0] raddr;
  logic [LABEL_W-1:0] rdata, lab_sel;
  logic [CNT_W-1:0] cnt_cur, cnt_lab;
  knn_label_ram u_ram (
    .clk(clk), .we(lbl_we), .waddr(lbl_waddr), .wdata(lbl_wdata), .raddr(raddr), .rdata(rdata)
  );
  // step doubles as read address pointer, class scan pointer and neighbour scan pointer
  always_comb begin
    raddr = '0;
    lab_sel = '0;
    cnt_cur = '0;
    cnt_lab = '0;
    for (int k = 0; k < K; k++)
      if (st_q.step == STEP_W'(k)) begin
        raddr = st_q.idx[k];
        lab_sel = st_q.lab[k];
      end
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (st_q.step == STEP_W'(c)) cnt_cur = st_q.cnt[c];
      if (lab_sel == LABEL_W'(c)) cnt_lab = st_q.cnt[c];
    end
  end
  always_comb begin
    st_d = st_q;
    st_d.res_valid = 1'b0;
    st_d.overrun = st_q.overrun | (nb_valid & st_q.busy);
    case (st_q.state)
      S_READ: begin
        for (int j = 0; j < K; j++)
          if (st_q.step == STEP_W'(j + 1)) st_d.lab[j] = rdata;
        for (int c = 0; c < NUM_CLASSES; c++)
          if (st_q.step != '0 && rdata == LABEL_W'(c)) st_d.cnt[c] = st_q.cnt[c] + 1'b1;
        st_d.step = st_q.step + 1'b1;
        if (st_q.step == STEP_W'(K)) begin
          st_d.state = S_MAX;
          st_d.step = '0;
        end
      end
      S_MAX: begin
        if (cnt_cur > st_q.mx) begin
          st_d.mx = cnt_cur;
          st_d.nmax = 2'd1;
        end else if (cnt_cur == st_q.mx && st_q.nmax != 2'd2) st_d.nmax = st_q.nmax + 2'd1;
        st_d.step = st_q.step + 1'b1;
        if (st_q.step == STEP_W'(NUM_CLASSES - 1)) begin
          st_d.state = S_PICK;
          st_d.step = '0;
        end
      end
      S_PICK: begin
        if (!st_q.found && lab_sel < LABEL_W'(NUM_CLASSES) && cnt_lab == st_q.mx) begin
          st_d.win = lab_sel;
          st_d.found = 1'b1;
        end
        st_d.step = st_q.step + 1'b1;
        if (st_q.step == STEP_W'(K - 1)) begin
          st_d.state = S_DONE;
          st_d.busy = 1'b0;
          st_d.res_valid = 1'b1;
          st_d.res_label = (st_q.mx == '0) ? '1 : st_d.win;
          st_d.res_votes = st_q.mx;
          st_d.res_tie = st_q.nmax == 2'd2 && st_q.mx != '0;
        end
      end
      S_DONE: st_d.state = S_IDLE;
      default: ;
    endcase
    // busy is low only in IDLE and DONE, so a query can start back-to-back from DONE
    if (nb_valid && !st_q.busy) begin
      st_d.state = S_READ;
      st_d.step = '0;
      st_d.idx = nb_idx;
      st_d.cnt = '0;
      st_d.mx = '0;
      st_d.nmax = '0;
      st_d.found = 1'b0;
      st_d.busy = 1'b1;
    end
    if (clr) st_d = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= '0;
    else st_q <= st_d;
  assign busy = st_q.busy;
  assign res_valid = st_q.res_valid;
  assign res_label = st_q.res_label;
  assign res_votes = st_q.res_votes;
  assign res_tie = st_q.res_tie;
  assign overrun = st_q.overrun;
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed and random queries checked against a counting reference model
module tb_knn_vote;
  import knn_vote_pkg::*;
  localparam int VW = K * IDX_W;
  logic clk = 0, rst = 1, clr = 0, lbl_we = 0, nb_valid = 0;
  logic [IDX_W-1:0] lbl_waddr = '0;
  logic [LABEL_W-1:0] lbl_wdata = '0;
  logic [VW-1:0] nb_idx = '0;
  logic busy, res_valid, res_tie, overrun;
  logic [LABEL_W-1:0] res_label;
  logic [CNT_W-1:0] res_votes;
  int checks = 0, failures = 0;
  int lbl_m [N_PTS];
  always #5 clk = ~clk;
  knn_vote dut (
    .clk(clk), .rst(rst), .clr(clr), .lbl_we(lbl_we), .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata),
    .nb_valid(nb_valid), .nb_idx(nb_idx), .busy(busy), .res_valid(res_valid), .res_label(res_label),
    .res_votes(res_votes), .res_tie(res_tie), .overrun(overrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [VW-1:0] pk(input int a, b, c, d, e, f);
    return {IDX_W'(f), IDX_W'(e), IDX_W'(d), IDX_W'(c), IDX_W'(b), IDX_W'(a)};
  endfunction
  task automatic predict(input logic [VW-1:0] v, output int lab, output int votes, output int tie);
    int cnt [NUM_CLASSES] = '{default: 0};
    int l, n;
    votes = 0;
    n = 0;
    lab = (1 << LABEL_W) - 1;
    for (int j = 0; j < K; j++) begin
      l = lbl_m[v[j*IDX_W +: IDX_W]];
      if (l < NUM_CLASSES) cnt[l]++;
    end
    for (int c = 0; c < NUM_CLASSES; c++) if (cnt[c] > votes) votes = cnt[c];
    for (int c = 0; c < NUM_CLASSES; c++) if (cnt[c] == votes) n++;
    tie = (n > 1 && votes > 0) ? 1 : 0;
    if (votes > 0)
      for (int j = K - 1; j >= 0; j--) begin
        l = lbl_m[v[j*IDX_W +: IDX_W]];
        if (l < NUM_CLASSES && cnt[l] == votes) lab = l;
      end
  endtask
  task automatic wr(input int a, input int d);
    lbl_we = 1;
    lbl_waddr = IDX_W'(a);
    lbl_wdata = LABEL_W'(d);
    @(negedge clk);
    lbl_we = 0;
    lbl_m[a] = d;
  endtask
  task automatic issue(input logic [VW-1:0] v);
    nb_valid = 1;
    nb_idx = v;
    @(negedge clk);
    nb_valid = 0;
  endtask
  task automatic await(input string tag, input logic [VW-1:0] v, input int base, input bit nxt_en,
                       input logic [VW-1:0] nxt);
    int lat = -1, el, ev, et;
    bit busy_ok = 1;
    predict(v, el, ev, et);
    for (int m = 0; m < 60 && lat < 0; m++) begin
      if (res_valid === 1'b1) begin
        lat = base + m + 1;
        check({tag, ".busy_done"}, busy, 0);
        check({tag, ".label"}, res_label, el);
        check({tag, ".votes"}, res_votes, ev);
        check({tag, ".tie"}, res_tie, et);
        if (nxt_en) begin
          nb_valid = 1;
          nb_idx = nxt;
        end
      end else if (busy !== 1'b1) busy_ok = 0;
      @(negedge clk);
      nb_valid = 0;
    end
    check({tag, ".latency"}, lat, 24);
    check({tag, ".busy_held"}, busy_ok, 1);
  endtask
  task automatic quiet(input string tag, input int cycles);
    int n = 0;
    repeat (cycles) begin
      if (res_valid !== 1'b0) n++;
      @(negedge clk);
    end
    check({tag, ".no_strobe"}, n, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [VW-1:0] v1, v2, va, vb;
    logic [63:0] r;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.res_valid", res_valid, 0);
    check("rst.res_label", res_label, 0);
    check("rst.res_votes", res_votes, 0);
    check("rst.res_tie", res_tie, 0);
    check("rst.overrun", overrun, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < N_PTS; i++) wr(i, i % 10);
    issue(pk(3, 13, 23, 4, 14, 5));
    await("maj", pk(3, 13, 23, 4, 14, 5), 0, 0, '0);
    check("maj.const_label", res_label, 3);
    check("maj.const_votes", res_votes, 3);
    check("maj.const_tie", res_tie, 0);
    issue(pk(7, 2, 12, 17, 9, 1));
    await("tie", pk(7, 2, 12, 17, 9, 1), 0, 0, '0);
    check("tie.const_label", res_label, 7);
    check("tie.const_votes", res_votes, 2);
    check("tie.const_tie", res_tie, 1);
    for (int j = 0; j < K; j++) wr(100 + j, 15);
    issue(pk(100, 101, 102, 103, 104, 105));
    await("inv", pk(100, 101, 102, 103, 104, 105), 0, 0, '0);
    check("inv.const_label", res_label, 15);
    check("inv.const_votes", res_votes, 0);
    check("inv.const_tie", res_tie, 0);
    v1 = pk(3, 13, 23, 33, 4, 5);
    v2 = pk(7, 17, 27, 37, 47, 57);
    issue(v1);
    repeat (4) @(negedge clk);
    nb_valid = 1;
    nb_idx = v2;
    @(negedge clk);
    nb_valid = 0;
    await("ovr", v1, 5, 0, '0);
    check("ovr.sticky", overrun, 1);
    quiet("ovr", 30);
    check("ovr.still_set", overrun, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("clr.overrun", overrun, 0);
    check("clr.res_label", res_label, 0);
    check("clr.res_votes", res_votes, 0);
    issue(v2);
    repeat (9) @(negedge clk);
    rst = 1;
    #1;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.res_valid", res_valid, 0);
    @(negedge clk);
    rst = 0;
    quiet("rst_mid", 30);
    issue(v2);
    await("rst_next", v2, 0, 0, '0);
    check("rst_next.const_label", res_label, 7);
    va = pk(1, 11, 2, 12, 22, 3);
    vb = pk(9, 19, 8, 18, 28, 0);
    issue(va);
    await("b2b_a", va, 0, 1, vb);
    await("b2b_b", vb, 0, 0, '0);
    for (int it = 0; it < 16; it++) begin
      repeat (4) wr($urandom_range(0, 127),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 3));
      r = {$urandom, $urandom};
      va = r[VW-1:0];
      r = {$urandom, $urandom};
      vb = r[VW-1:0];
      issue(va);
      if (it % 3 == 0) begin
        await("rnd_b2b_a", va, 0, 1, vb);
        await("rnd_b2b_b", vb, 0, 0, '0);
      end else await("rnd", va, 0, 0, '0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
